// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the pattern sequencer: byte codes, FSM states and
// the octave-7 phase increment table (48 kHz sample rate, 18-bit phase).
package sequencer_pkg;

    localparam logic [7:0] REST = 8'h00;
    localparam logic [7:0] HOLD = 8'hFF;
    localparam logic [7:0] END  = 8'hFE;
    localparam logic [7:0] LAST_NOTE = 8'h60;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_DECODE,
        ST_READY
    } seq_state_t;

    // Octave-7 increments; lower octaves are derived by right shifts.
    function automatic logic [17:0] base_phase(input logic [6:0] semitone);
        case (semitone)
            7'd0:    return 18'd11431;
            7'd1:    return 18'd12110;
            7'd2:    return 18'd12830;
            7'd3:    return 18'd13593;
            7'd4:    return 18'd14402;
            7'd5:    return 18'd15258;
            7'd6:    return 18'd16165;
            7'd7:    return 18'd17127;
            7'd8:    return 18'd18145;
            7'd9:    return 18'd19224;
            7'd10:   return 18'd20367;
            7'd11:   return 18'd21578;
            default: return 18'd0;
        endcase
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Pattern ROM bus plus the voice controls handed to the pulse channel.
interface note_sequencer_if #(
    parameter int PHASE_BITS = 18,
    parameter int ADDR_BITS  = 8
);
    logic [ADDR_BITS-1:0]  rom_addr;
    logic [7:0]            rom_data;
    logic                  song_clk;
    logic                  note_trigger;
    logic                  note_on;
    logic [PHASE_BITS-1:0] phase_inc;

    modport master (
        output rom_addr,
        input  rom_data,
        output song_clk,
        output note_trigger,
        output note_on,
        output phase_inc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  song_clk,
        input  note_trigger,
        input  note_on,
        input  phase_inc
    );
endinterface

// File: rtl/note_sequencer_decode.sv
// Combinational pattern-byte decoder: classifies the byte and, for notes,
// derives the oscillator increment from the octave-7 table.
module note_decode
    import sequencer_pkg::*;
#(
    parameter int PHASE_BITS = 18
) (
    input  logic [7:0]            code,
    output logic                  is_note,
    output logic                  is_rest,
    output logic                  is_end,
    output logic [PHASE_BITS-1:0] phase_inc
);

    logic [6:0] note_idx;
    logic [6:0] rem [4];
    logic [2:0] octave;
    logic [2:0] shift;

    assign note_idx = code[6:0] - 7'd1;
    assign rem[0]   = note_idx;

    // Restoring compare-subtract against 48, 24, 12 yields octave bits MSB first.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_oct
            localparam logic [6:0] STEP = 7'(12 << (2 - gi));
            assign octave[2-gi] = (rem[gi] >= STEP);
            assign rem[gi+1]    = octave[2-gi] ? (rem[gi] - STEP) : rem[gi];
        end
    endgenerate

    assign shift     = 3'd7 - octave;
    assign is_note   = (code != REST) && (code <= LAST_NOTE);
    assign is_rest   = (code == REST);
    assign is_end    = (code == END);
    assign phase_inc = PHASE_BITS'(base_phase(rem[3]) >> shift);

endmodule

// File: rtl/note_sequencer.sv
// Row sequencer: counts tick strobes into rows, prefetches one pattern byte
// per row and releases the decoded note exactly on the row tick.
module note_sequencer
    import sequencer_pkg::*;
#(
    parameter int PHASE_BITS    = 18,
    parameter int ADDR_BITS     = 8,
    parameter int TICKS_PER_ROW = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_clk,
    note_sequencer_if.master    bus,
    output logic                underrun
);

    localparam logic [7:0] TCNT_LAST = 8'(TICKS_PER_ROW - 1);

    seq_state_t            state_reg;
    seq_state_t            state_next;
    logic [ADDR_BITS-1:0]  ptr_reg;
    logic [7:0]            tcnt_reg;
    logic [7:0]            byte_reg;
    logic                  pend_trig_reg;
    logic                  pend_note_reg;
    logic                  pend_rest_reg;
    logic [PHASE_BITS-1:0] pend_inc_reg;
    logic                  note_on_reg;
    logic [PHASE_BITS-1:0] phase_inc_reg;
    logic                  underrun_reg;

    logic                  row_tick;
    logic                  apply_row;
    logic                  starved;
    logic                  dec_is_note;
    logic                  dec_is_rest;
    logic                  dec_is_end;
    logic [PHASE_BITS-1:0] dec_inc;

    note_decode #(
        .PHASE_BITS (PHASE_BITS)
    ) u_decode (
        .code      (byte_reg),
        .is_note   (dec_is_note),
        .is_rest   (dec_is_rest),
        .is_end    (dec_is_end),
        .phase_inc (dec_inc)
    );

    assign row_tick = tick_clk && (tcnt_reg == 8'd0);
    assign starved  = row_tick && (state_reg != ST_READY);

    always_comb begin
        state_next = state_reg;
        apply_row  = 1'b0;
        case (state_reg)
            ST_FETCH:  state_next = ST_WAIT;
            ST_WAIT:   state_next = ST_DECODE;
            ST_DECODE: state_next = dec_is_end ? ST_FETCH : ST_READY;
            ST_READY: begin
                if (row_tick) begin
                    apply_row  = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            default:   state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            ptr_reg       <= '0;
            tcnt_reg      <= 8'd0;
            byte_reg      <= 8'd0;
            pend_trig_reg <= 1'b0;
            pend_note_reg <= 1'b0;
            pend_rest_reg <= 1'b0;
            pend_inc_reg  <= '0;
            note_on_reg   <= 1'b0;
            phase_inc_reg <= '0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (tick_clk) begin
                tcnt_reg <= (tcnt_reg == TCNT_LAST) ? 8'd0 : tcnt_reg + 8'd1;
            end

            if (state_reg == ST_WAIT) begin
                byte_reg <= bus.rom_data;
            end

            // End marker rewinds and refetches within the same row.
            if (state_reg == ST_DECODE) begin
                if (dec_is_end) begin
                    ptr_reg <= '0;
                end else begin
                    pend_trig_reg <= dec_is_note;
                    pend_note_reg <= dec_is_note;
                    pend_rest_reg <= dec_is_rest;
                    if (dec_is_note) begin
                        pend_inc_reg <= dec_inc;
                    end
                end
            end

            if (apply_row) begin
                ptr_reg <= ptr_reg + ADDR_BITS'(1);
                if (pend_note_reg) begin
                    note_on_reg   <= 1'b1;
                    phase_inc_reg <= pend_inc_reg;
                end else if (pend_rest_reg) begin
                    note_on_reg <= 1'b0;
                end
            end

            if (starved) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    assign bus.rom_addr     = ptr_reg;
    assign bus.song_clk     = row_tick;
    assign bus.note_trigger = (state_reg == ST_READY) && pend_trig_reg;
    assign bus.note_on      = note_on_reg;
    assign bus.phase_inc    = phase_inc_reg;
    assign underrun         = underrun_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: row events are queued when a row tick is
// driven and checked when song_clk shows up.
module tb_note_sequencer;

    logic clk;
    logic rst;
    logic tick_clk;
    logic underrun;

    note_sequencer_if #(.PHASE_BITS(18), .ADDR_BITS(8)) bus ();

    note_sequencer #(
        .PHASE_BITS    (18),
        .ADDR_BITS     (8),
        .TICKS_PER_ROW (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_clk (tick_clk),
        .bus      (bus.master),
        .underrun (underrun)
    );

    logic [7:0] rom [256];

    always_ff @(posedge clk) begin
        bus.rom_data <= rom[bus.rom_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit trig;
        bit on;
        int inc;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    int base_tbl[12] = '{11431, 12110, 12830, 13593, 14402, 15258,
                         16165, 17127, 18145, 19224, 20367, 21578};

    int  m_ptr;
    int  m_tcnt;
    bit  m_on;
    int  m_inc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_inc(input int b);
        int n;
        n = b - 1;
        return base_tbl[n % 12] >> (7 - n / 12);
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_tcnt = 0;
        m_on   = 1'b0;
        m_inc  = 0;
        sb.delete();
    endtask

    // One tick strobe followed by idle cycles; starved marks a row tick that
    // the sequencer cannot yet serve.
    task automatic step(input int gap, input bit starved);
        bit   is_row;
        bit   popped;
        exp_t e;
        exp_t got;
        int   b;
        int   idle;
        is_row = (m_tcnt == 0);
        m_tcnt = (m_tcnt == 5) ? 0 : m_tcnt + 1;
        popped = 1'b0;
        if (is_row) begin
            e.trig = 1'b0;
            if (!starved) begin
                b = int'(rom[m_ptr[7:0]]);
                if (b == 8'hFE) begin
                    m_ptr = 0;
                    b = int'(rom[0]);
                end
                if (b >= 1 && b <= 8'h60) begin
                    e.trig = 1'b1;
                    m_on   = 1'b1;
                    m_inc  = model_inc(b);
                end else if (b == 0) begin
                    m_on = 1'b0;
                end
                m_ptr = (m_ptr + 1) % 256;
            end
            e.on  = m_on;
            e.inc = m_inc;
            sb.push_back(e);
        end

        @(posedge clk);
        #1 tick_clk = 1'b1;
        @(negedge clk);
        check("song_clk", 32'(bus.song_clk), 32'(is_row));
        if (bus.song_clk) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                got    = sb.pop_front();
                popped = 1'b1;
                check("note_trigger", 32'(bus.note_trigger), 32'(got.trig));
            end
        end
        @(posedge clk);
        #1 tick_clk = 1'b0;
        idle = (gap > 1) ? gap - 1 : 1;
        if (popped) begin
            check("note_on", 32'(bus.note_on), 32'(got.on));
            check("phase_inc", 32'(bus.phase_inc), 32'(got.inc));
            check("rom_addr_next", 32'(bus.rom_addr), 32'(m_ptr));
            if (starved) begin
                check("underrun_set", 32'(underrun), 32'd1);
            end else if (gap >= 5) begin
                repeat (3) @(posedge clk);
                #1;
                check("rom_addr_settled", 32'(bus.rom_addr),
                      (rom[m_ptr[7:0]] == 8'hFE) ? 32'd0 : 32'(m_ptr));
                idle = idle - 3;
            end
        end
        repeat (idle) @(posedge clk);
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_song_clk"}, 32'(bus.song_clk), 32'd0);
        check({phase, "_note_trigger"}, 32'(bus.note_trigger), 32'd0);
        check({phase, "_note_on"}, 32'(bus.note_on), 32'd0);
        check({phase, "_phase_inc"}, 32'(bus.phase_inc), 32'd0);
        check({phase, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        check({phase, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        rom[0] = 8'h0A;   // note 9: semitone 9, octave 0 -> 150
        rom[1] = 8'h00;   // rest
        rom[2] = 8'h5A;   // note 89: semitone 5, octave 7 -> 15258
        rom[3] = 8'hFF;   // hold
        rom[4] = 8'h70;   // undefined code, treated as hold
        rom[5] = 8'hFE;   // end of pattern

        rst      = 1'b1;
        tick_clk = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (8) @(posedge clk);

        // Seven rows at comfortable spacing: note, rest, note, hold, hold,
        // end marker replaying row 0, then the rest again.
        for (int t = 0; t < 42; t++) begin
            step(10, 1'b0);
        end
        check("underrun_clear", 32'(underrun), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Tick right after reset, then tightly spaced ticks.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step(2, 1'b1);
        for (int t = 0; t < 5; t++) begin
            step(2, 1'b0);
        end
        step(10, 1'b0);
        check("underrun_sticky", 32'(underrun), 32'd1);
        check("sb_drained2", 32'(sb.size()), 32'd0);

        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("rst_pulse");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Row-based pattern sequencer that drives one pulse voice.
- Counts `tick_clk` strobes into rows and fetches one pattern byte per row from an external synchronous ROM.
- Decodes each byte into a note event and presents `song_clk`, `note_trigger`, `note_on` and `phase_inc` to the downstream pulse channel.
- Timing is arranged so a trigger lands exactly on the row tick that the channel samples.

## Interface
- `PHASE_BITS`, 18, width of `phase_inc`; must match the channel.
- `ADDR_BITS`, 8, pattern ROM address width.
- `TICKS_PER_ROW`, 6, tick strobes per row; range 1..255.
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `tick_clk` in 1: one-`clk` tick strobe.
- `rom_addr` out `ADDR_BITS`: pattern ROM address.
- `rom_data` in 8: ROM byte, valid the cycle after `rom_addr` is presented.
- `song_clk` out 1: row-tick strobe, coincident with `tick_clk`.
- `note_trigger` out 1: the upcoming row starts a note; valid whenever `song_clk` is high.
- `note_on` out 1: a note is sounding.
- `phase_inc` out `PHASE_BITS`: oscillator increment.
- `underrun` out 1: sticky flag; a row tick arrived before the prefetch completed.

## Operation
Byte encoding:
- 0x00: rest. `note_on` goes to 0 and `phase_inc` is held.
- 0x01..0x60: note n = byte−1, where octave = n/12 and semitone = n%12. `phase_inc` = BASE[semitone] >> (7−octave); `note_on` = 1; trigger = 1.
- 0xFE: end of pattern. The row pointer resets to 0 and the fetch repeats within the same row.
- 0xFF, and 0x61..0xFD: hold. No trigger; outputs unchanged.

FSM states: FETCH → WAIT → DECODE → READY.
- FETCH: drive `rom_addr` = ptr.
- WAIT: register `rom_data`.
- DECODE: if the byte is 0xFE, set ptr to 0 and go to FETCH. Otherwise compute the pending trigger, note_on and inc, then go to READY.
- READY: wait for a row tick.

Tick counter `tcnt`:
- A row tick is `tick_clk` && `tcnt`==0.
- On every `tick_clk`, `tcnt` ← (`tcnt`==`TICKS_PER_ROW`−1) ? 0 : `tcnt`+1.
- `song_clk` = row tick, combinational.

Row tick while in READY:
- `note_trigger` = pending trigger, combinational from pending registers.
- At the closing edge: `note_on` and `phase_inc` take the pending values, ptr ← ptr+1 (wraps at 2^`ADDR_BITS`), and the FSM goes to FETCH.

Row tick while not in READY:
- `note_trigger` = 0, outputs unchanged, ptr unchanged.
- `underrun` ← 1. The flag clears only on `rst`.
- The late row is used at the next row tick.

Other rules:
- The semitone/octave split is a combinational compare-subtract chain on a 7-bit value; no divider.
- Shift result is truncated, not rounded.

## Timing
- Reset values: ptr=0, `tcnt`=0, FSM=FETCH, `rom_addr`=0, `note_on`=0, `phase_inc`=0, `note_trigger`=0, `song_clk`=0, `underrun`=0.
- The first `tick_clk` after reset is a row tick for row 0.
- Prefetch latency is 3 clk after reset or a row tick, or 6 clk when it hits 0xFE.
- `tick_clk` strobes must be ≥8 clk apart; a violation shows up as `underrun`.
- `note_on` and `phase_inc` change exactly one clk after `song_clk`.
- `note_trigger` is valid in the `song_clk` cycle.
- Between rows, `note_trigger` may show the pending value; it is meaningful only when qualified by `song_clk`.
- `rst` mid-fetch or coincident with a tick: reset wins and the tick is dropped.
- `tick_clk` in the same cycle as the DECODE→READY transition is not a READY tick and counts as an underrun.

## Structure
- Package `sequencer_pkg` holds:
  - byte codes `REST`=0x00, `HOLD`=0xFF, `END`=0xFE;
  - the FSM state enum;
  - the 12-entry octave-7 BASE table (48 kHz, 18-bit phase): 11431, 12110, 12830, 13593, 14402, 15258, 16165, 17127, 18145, 19224, 20367, 21578.
- One sub-module is natural: `note_decode`, combinational. It maps byte → {is_note, is_rest, is_end, phase_inc}.

## Test plan
- Reset, ROM[0]=0x0A, tick spacing 16 clk → first tick: `song_clk`=1, `note_trigger`=1; next clk: `note_on`=1, `phase_inc`=150.
- ROM[1]=0x5A, `TICKS_PER_ROW`=6 → `song_clk` on ticks 0, 6, 12 only; after tick 6, `phase_inc`=15258 with trigger at tick 6.
- ROM[1]=0x00 after a note → at tick 6, `note_trigger`=0; `note_on`→0; `phase_inc` stays 150.
- ROM[1]=0xFF and ROM[2]=0x70 → no trigger at either row; `note_on`/`phase_inc` unchanged.
- ROM[3]=0xFE → the fourth row tick replays ROM[0]: trigger=1, `phase_inc`=150, `rom_addr` sequence 3→0.
- `tick_clk` spaced 2 clk → `underrun`=1 sticky, no trigger on the starved row; `rst` pulse clears all outputs to 0.
